// File: rtl/l1_data_array_nway.sv
// l1_data_array_nway: WAYS x SETS array of LW-bit lines with per-byte write enables.
// Latency: reads return one cycle after rd_req, with write-first forwarding on a same-cycle hit.
// Backpressure: none; accepts a read and a write every READY cycle, and ignores both during the clear sweep.
//
// Ports:
//   clk, rst                   - sole clock (rising edge), synchronous active-low reset
//   rd_req/rd_index/rd_way     - read request and address
//   wr_be/wr_index/wr_way/wr_data - byte-enabled write (wr_be == 0 is a no-op)
//   rd_data/rd_valid           - registered read line and its qualifier
//   init_busy                  - high while the post-reset clear sweep runs
module l1_data_array_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_BYTES = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_req,
  input  logic [$clog2(SETS)-1:0]     rd_index,
  input  logic [$clog2(WAYS)-1:0]     rd_way,
  input  logic [LINE_BYTES-1:0]       wr_be,
  input  logic [$clog2(SETS)-1:0]     wr_index,
  input  logic [$clog2(WAYS)-1:0]     wr_way,
  input  logic [8*LINE_BYTES-1:0]     wr_data,
  output logic [8*LINE_BYTES-1:0]     rd_data,
  output logic                        rd_valid,
  output logic                        init_busy
);

  localparam int LW = 8 * LINE_BYTES;
  localparam int IW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);

  typedef enum logic {INIT, READY} state_t;

  state_t          state;
  logic [IW-1:0]   cnt;
  logic [LW-1:0]   mem [WAYS][SETS];
  logic [LW-1:0]   be_mask;
  logic [LW-1:0]   rd_stored;
  logic [LW-1:0]   rd_line;
  logic            wr_hit;

  // Expand byte enables into a bit mask so writes and forwarding are plain
  // bitwise merges.
  for (genvar b = 0; b < LINE_BYTES; b++) begin : g_mask
    assign be_mask[8*b +: 8] = {8{wr_be[b]}};
  end

  assign rd_stored = mem[rd_way][rd_index];
  assign wr_hit    = (wr_index == rd_index) && (wr_way == rd_way);

  // Write-first: a same-cycle write to the read address overrides the enabled bytes.
  always_comb begin
    rd_line = rd_stored;
    if (wr_hit) begin
      rd_line = (rd_stored & ~be_mask) | (wr_data & be_mask);
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      case (state)
        INIT: begin
          rd_valid <= 1'b0;
          cnt      <= cnt + 1'b1;
          if (cnt == IW'(SETS - 1)) begin
            state     <= READY;
            init_busy <= 1'b0;
          end
        end
        READY: begin
          rd_valid <= rd_req;
          if (rd_req) begin
            rd_data <= rd_line;
          end
        end
        default: begin
          state     <= INIT;
          cnt       <= '0;
          init_busy <= 1'b1;
          rd_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; only the sweep clears it, one set per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT) begin
        for (int w = 0; w < WAYS; w++) begin
          mem[WW'(w)][cnt] <= '0;
        end
      end else if (wr_be != '0) begin
        mem[wr_way][wr_index] <= (mem[wr_way][wr_index] & ~be_mask) | (wr_data & be_mask);
      end
    end
  end

endmodule

// File: tb/tb_l1_data_array_nway.sv
module tb_l1_data_array_nway;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req;
  logic [3:0]   rd_index;
  logic [0:0]   rd_way;
  logic [31:0]  wr_be;
  logic [3:0]   wr_index;
  logic [0:0]   wr_way;
  logic [255:0] wr_data;
  logic [255:0] rd_data;
  logic         rd_valid;
  logic         init_busy;

  int tests = 0;
  int fails = 0;

  // Reference contents: one entry per (way, set), updated byte by byte.
  logic [255:0] model [2][16];

  l1_data_array_nway #(.WAYS(2), .SETS(16), .LINE_BYTES(32)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_index(rd_index), .rd_way(rd_way),
    .wr_be(wr_be), .wr_index(wr_index), .wr_way(wr_way), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic idle_inputs();
    rd_req = 0; rd_index = 0; rd_way = 0;
    wr_be = 0; wr_index = 0; wr_way = 0; wr_data = '0;
  endtask

  task automatic model_clear();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 16; s++) model[w][s] = '0;
  endtask

  // Reset outputs, sweep length, writes/reads during INIT dropped, all lines zero.
  task automatic test_reset();
    int n;
    idle_inputs();
    rst = 0;
    cycle(); cycle();
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
    tests++; if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL reset_init_busy got %0b want 1", init_busy); end
    // Attempt a write to set 0 (cleared first) and reads throughout the sweep.
    rd_req = 1; rd_way = 1; rd_index = 0;
    wr_be = '1; wr_way = 1; wr_index = 0; wr_data = {32{8'hEE}};
    rst = 1;
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      cycle();
      n++;
      tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL init_rd_valid cycle %0d got %0b want 0", n, rd_valid); end
    end
    tests++; if (n != 16) begin fails++; $display("FAIL init_length got %0d cycles want 16", n); end
    idle_inputs();
    model_clear();
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s < 16; s++) begin
        rd_req = 1; rd_way = w[0:0]; rd_index = s[3:0];
        cycle();
        tests++; if (rd_valid !== 1'b1 || rd_data !== model[w][s]) begin
          fails++; $display("FAIL init_zero w%0d s%0d got v=%0b %h want v=1 %h", w, s, rd_valid, rd_data, model[w][s]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_full_write();
    wr_be = '1; wr_way = 1; wr_index = 3; wr_data = {32{8'hA5}};
    cycle();
    model[1][3] = {32{8'hA5}};
    idle_inputs();
    rd_req = 1; rd_way = 1; rd_index = 3;
    cycle();
    tests++; if (rd_valid !== 1'b1 || rd_data !== {32{8'hA5}}) begin
      fails++; $display("FAIL a5_w1s3 got v=%0b %h want v=1 %h", rd_valid, rd_data, {32{8'hA5}});
    end
    rd_way = 0;
    cycle();
    tests++; if (rd_valid !== 1'b1 || rd_data !== '0) begin
      fails++; $display("FAIL a5_w0s3 got v=%0b %h want v=1 0", rd_valid, rd_data);
    end
    // Idle read: valid drops, data holds the last line.
    rd_req = 0;
    cycle();
    tests++; if (rd_valid !== 1'b0 || rd_data !== '0) begin
      fails++; $display("FAIL idle_hold got v=%0b %h want v=0 0", rd_valid, rd_data);
    end
    idle_inputs();
  endtask

  task automatic test_forward_partial();
    logic [255:0] exp;
    wr_be = '1; wr_way = 0; wr_index = 7; wr_data = {32{8'h11}};
    cycle();
    wr_be = 32'h0000_000F; wr_data = {32{8'hFF}};
    rd_req = 1; rd_way = 0; rd_index = 7;
    cycle();
    exp = {{28{8'h11}}, {4{8'hFF}}};
    model[0][7] = exp;
    tests++; if (rd_valid !== 1'b1 || rd_data !== exp) begin
      fails++; $display("FAIL fwd_partial got v=%0b %h want v=1 %h", rd_valid, rd_data, exp);
    end
    wr_be = 0;
    cycle();
    tests++; if (rd_data !== exp) begin fails++; $display("FAIL fwd_stored got %h want %h", rd_data, exp); end
    idle_inputs();
  endtask

  task automatic test_no_forward();
    logic [255:0] p5, p6;
    p5 = rand_line(); p6 = rand_line();
    wr_be = '1; wr_way = 0; wr_index = 6; wr_data = p6;
    cycle();
    model[0][6] = p6;
    wr_index = 5; wr_data = p5;
    rd_req = 1; rd_way = 0; rd_index = 6;
    cycle();
    model[0][5] = p5;
    tests++; if (rd_valid !== 1'b1 || rd_data !== p6) begin
      fails++; $display("FAIL nofwd_old got %h want %h", rd_data, p6);
    end
    wr_be = 0; rd_index = 5;
    cycle();
    tests++; if (rd_valid !== 1'b1 || rd_data !== p5) begin
      fails++; $display("FAIL nofwd_new got %h want %h", rd_data, p5);
    end
    idle_inputs();
  endtask

  // Random back-to-back traffic with frequent address collisions.
  task automatic test_random();
    logic [255:0] exp, last, wd;
    logic [31:0]  be;
    int ri, rw, wi, ww;
    bit rq;
    last = rd_data;
    for (int n = 0; n < 400; n++) begin
      rq = ($urandom_range(0, 3) != 0);
      ri = $urandom_range(0, 15); rw = $urandom_range(0, 1);
      wi = $urandom_range(0, 1) ? ri : $urandom_range(0, 15);
      ww = $urandom_range(0, 3) != 0 ? rw : $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0: be = 32'h0;
        1: be = 32'hFFFF_FFFF;
        default: be = $urandom;
      endcase
      wd = rand_line();
      rd_req = rq; rd_index = ri[3:0]; rd_way = rw[0:0];
      wr_be = be; wr_index = wi[3:0]; wr_way = ww[0:0]; wr_data = wd;
      // Expected read sees the write's enabled bytes only on an exact address match.
      exp = model[rw][ri];
      if (wi == ri && ww == rw)
        for (int b = 0; b < 32; b++) if (be[b]) exp[8*b +: 8] = wd[8*b +: 8];
      for (int b = 0; b < 32; b++) if (be[b]) model[ww][wi][8*b +: 8] = wd[8*b +: 8];
      if (rq) last = exp;
      cycle();
      tests++; if (rd_valid !== rq || rd_data !== last) begin
        fails++; $display("FAIL random n%0d got v=%0b %h want v=%0b %h", n, rd_valid, rd_data, rq, last);
      end
    end
    idle_inputs();
  endtask

  // Reset from READY, then again mid-sweep; the restarted sweep clears stale data.
  task automatic test_reset_mid_sweep();
    int n;
    wr_be = '1; wr_way = 1; wr_index = 15; wr_data = {32{8'h5A}};
    cycle();
    idle_inputs();
    rst = 0;
    cycle();
    tests++; if (rd_valid !== 1'b0 || rd_data !== '0 || init_busy !== 1'b1) begin
      fails++; $display("FAIL ready_reset got v=%0b busy=%0b %h want v=0 busy=1 0", rd_valid, init_busy, rd_data);
    end
    rst = 1;
    repeat (7) cycle();
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL midsweep_busy got %0b want 1", init_busy); end
    rst = 0;
    cycle();
    rst = 1;
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    tests++; if (n != 16) begin fails++; $display("FAIL restart_length got %0d cycles want 16", n); end
    model_clear();
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s < 16; s++) begin
        rd_req = 1; rd_way = w[0:0]; rd_index = s[3:0];
        cycle();
        tests++; if (rd_valid !== 1'b1 || rd_data !== model[w][s]) begin
          fails++; $display("FAIL restart_zero w%0d s%0d got v=%0b %h want v=1 0", w, s, rd_valid, rd_data);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_full_write();
    test_forward_partial();
    test_no_forward();
    test_random();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/l1_data_array_nway.md
L1_DATA_ARRAY_NWAY -- requirements
Module: l1_data_array_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2, meaning the number of ways per set; legal values are powers of two >= 2.
REQ-002 SHALL have parameter SETS, default 16, meaning the number of sets; legal values are powers of two >= 2.
REQ-003 SHALL have parameter LINE_BYTES, default 32, meaning the bytes per line; line width is LW = 8*LINE_BYTES.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-low reset.
REQ-007 SHALL have port rd_req  input  1  read request, sampled each clk.
REQ-008 SHALL have port rd_index  input  log2(SETS)  read set.
REQ-009 SHALL have port rd_way  input  log2(WAYS)  read way.
REQ-010 SHALL have port wr_be  input  LINE_BYTES  per-byte write enable.
REQ-011 SHALL have port wr_index  input  log2(SETS)  write set.
REQ-012 SHALL have port wr_way  input  log2(WAYS)  write way.
REQ-013 SHALL have port wr_data  input  LW  write line.
REQ-014 SHALL have port rd_data  output  LW  registered read line.
REQ-015 SHALL have port rd_valid  output  1  rd_data is valid this cycle.
REQ-016 SHALL have port init_busy  output  1  clear sweep in progress; requests are ignored while it is high.

Function
REQ-017 SHALL store WAYS*SETS lines of LW bits, with each byte individually writable.
REQ-018 SHALL implement a two-state FSM, INIT and READY; reset forces INIT with the sweep counter at 0.
REQ-019 SHALL, in INIT, zero all ways of set[counter] each cycle and increment the counter; the transition to READY occurs on the cycle after counter == SETS-1 is cleared, so INIT lasts exactly SETS cycles after reset release.
REQ-020 SHALL drive init_busy = 1 exactly while in INIT.
REQ-021 SHALL, in INIT, drop all writes and ignore rd_req; rd_valid stays 0.
REQ-022 SHALL, in READY, write byte i of wr_data into [wr_way][wr_index] at the clk edge when wr_be[i] = 1; all other bytes hold. wr_be = 0 is a no-op.
REQ-023 SHALL have a read latency of exactly 1 cycle: rd_req = 1 at edge t gives rd_valid = 1 and rd_data = line[rd_way][rd_index] after edge t.
REQ-024 SHALL give reads write-first forwarding: if a read and a write in the same cycle target the same index and way, rd_data byte i = wr_data byte i where wr_be[i] = 1, and the stored byte otherwise.
REQ-025 SHALL apply no forwarding when a same-cycle read and write differ in index or way; the read returns the pre-write contents.
REQ-026 SHALL drive rd_valid = 0 on any cycle following rd_req = 0; rd_data holds its last value.
REQ-027 SHALL accept back-to-back reads every cycle with full throughput and no stalls.
REQ-028 SHALL complete a read issued on the last INIT cycle as ignored; the first accepted read is in the first READY cycle and returns zeros unless written.

Reset
REQ-029 SHALL, with rst = 0 at a clk edge, set rd_data = 0, rd_valid = 0, init_busy = 1, state = INIT, and counter = 0.
REQ-030 SHALL restart the sweep from set 0 when rst is asserted mid-INIT or mid-READY; contents are not guaranteed until the sweep completes.
REQ-031 SHALL leave array contents untouched by rst itself; clearing is done only by the sweep.

Verification
REQ-032 SHALL verify: release rst with SETS = 16 -> init_busy high for exactly 16 cycles, then low; a read of every (way, set) returns 0.
REQ-033 SHALL verify: write 0xA5 to all bytes of way 1 set 3, then read way 1 set 3 next cycle -> rd_valid = 1 and rd_data = all bytes 0xA5; way 0 set 3 reads 0.
REQ-034 SHALL verify: with line = all 0x11, write wr_be = 0x0000_000F, data all 0xFF, plus a same-cycle read of the same index/way -> rd_data bytes 0-3 = 0xFF, bytes 4-31 = 0x11.
REQ-035 SHALL verify: same-cycle write to set 5 and read of set 6 -> read returns old set 6 data; a following read of set 5 shows the write.
REQ-036 SHALL verify: a write or read issued during INIT -> write lost (reads 0 after sweep) and rd_valid stays 0.
REQ-037 SHALL verify: assert rst at sweep cycle 7 for 1 cycle -> init_busy stays high for 16 more cycles after release, and stale data is cleared.
